contador_segundos: RTL and testbench
====================================

Name: contador_segundos

Overview:
Elapsed-seconds timebase. Divides the system clock down to a 1 Hz tick and accumulates a 32-bit seconds count, seg_total. seg_total drives the seconds-to-calendar converter directly (its in_seg input). Provides start/stop/clear/load control, a lap-capture register and a wrap flag.

Parameters:
CLK_DIV, 50000000, clk cycles per second; legal range 2..2^32-1.
MAX_SEG, 32'hFFFFFFFF, last count value before wrap-around to 0.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  level sampled each edge; request counting
stop  input  1  level sampled each edge; request pause
clear  input  1  zero count, prescaler and overflow; force PARADO
load  input  1  load seg_total from load_val
load_val  input  32  value for load (must be <= MAX_SEG)
captura  input  1  latch seg_total into seg_captura
seg_total  output  32  current elapsed seconds (to converter in_seg)
seg_valid  output  1  one-cycle pulse on the cycle seg_total changed by tick, load or clear
seg_captura  output  32  last captured value
contando  output  1  high while state = CONTANDO
overflow  output  1  sticky: count wrapped MAX_SEG -> 0

Behaviour:
- Reset (rst_n low, asynchronous, any time incl. mid-count): state PARADO, prescaler 0, seg_total 0, seg_captura 0, seg_valid 0, contando 0, overflow 0. Release is synchronous to the next clk edge.
- States: PARADO, CONTANDO. contando is a registered decode of the state.
- Transitions:
  - PARADO -> CONTANDO on start.
  - CONTANDO -> PARADO on stop.
  - start and stop together: stop wins.
  - clear forces PARADO from either state.
- Command priority per edge: clear > load > tick.
  - clear: seg_total 0, prescaler 0, overflow 0, seg_valid 1.
  - load: seg_total <= load_val, prescaler 0, overflow 0, seg_valid 1; state unchanged (start/stop still apply the same edge).
- Prescaler (32-bit): increments only in CONTANDO. Holds its value in PARADO, so a pause does not lose the fractional second.
- Tick: occurs when prescaler = CLK_DIV-1 at a CONTANDO edge. On that edge, prescaler <= 0 and seg_total <= seg_total+1, with seg_valid <= 1 the same edge.
- First increment latency: start sampled at edge 0 from a zeroed prescaler -> first increment at edge CLK_DIV. Thereafter one increment every CLK_DIV edges.
- A stop sampled on the same edge as a tick: the tick is still applied, then the state goes to PARADO.
- Wrap-around: a tick with seg_total = MAX_SEG -> seg_total <= 0 and overflow <= 1. overflow stays set until clear, load or reset.
- Capture: captura latches the pre-edge value of seg_total, including on tick, clear and load edges. Works in any state.
- seg_valid is 0 on all edges not listed above.
- Arithmetic is unsigned 32-bit; there is no intermediate wider than 32 bits.

Test Plan:
- CLK_DIV=4: reset, start pulse at edge 0 -> seg_total 1 at edge 4, 2 at edge 8, 3 at edge 12; seg_valid high exactly on edges 4, 8, 12.
- CLK_DIV=4: start, stop after 6 edges (prescaler=2), hold 10 edges, restart -> seg_total stays 1 while paused; becomes 2 exactly 2 edges after restart.
- MAX_SEG=5, load_val=5 then start -> after 4 edges seg_total 0 and overflow 1; clear -> overflow 0, seg_total 0, contando 0.
- load (load_val=86399) and clear asserted together while running -> seg_total 0, state PARADO; load alone while running -> seg_total 86399 and counting continues with prescaler 0.
- captura on a tick edge with seg_total 7 -> seg_captura 7 and seg_total 8; start+stop together from PARADO -> stays PARADO.
- rst_n driven low mid-count between clock edges -> all outputs 0 immediately, without waiting for a clk edge; resume only after start.

Source files
------------

// File: rtl/contador_segundos.sv
// contador_segundos
// Elapsed-seconds timebase. A 32-bit prescaler divides clk down to a 1 Hz
// tick and seg_total accumulates whole seconds. seg_total feeds the
// seconds-to-calendar converter (its in_seg input) directly.
//
// Parameters:
//   CLK_DIV  clk cycles per second (2 .. 2^32-1)
//   MAX_SEG  last count value before seg_total wraps to 0
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous reset, active-low
//   start        request counting (level, sampled each edge)
//   stop         request pause (level, sampled each edge; beats start)
//   clear        zero count, prescaler and overflow; forces PARADO
//   load         load seg_total from load_val, prescaler and overflow zeroed
//   load_val     value for load (must be <= MAX_SEG)
//   captura      latch the pre-edge seg_total into seg_captura
//   seg_total    current elapsed seconds
//   seg_valid    one-cycle pulse when seg_total changed by tick, load or clear
//   seg_captura  last captured value
//   contando     high while counting
//   overflow     sticky flag: count wrapped MAX_SEG -> 0
module contador_segundos #(
  parameter logic [31:0] CLK_DIV = 32'd50000000,
  parameter logic [31:0] MAX_SEG = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        captura,
  output logic [31:0] seg_total,
  output logic        seg_valid,
  output logic [31:0] seg_captura,
  output logic        contando,
  output logic        overflow
);

  typedef enum logic {
    PARADO   = 1'b0,
    CONTANDO = 1'b1
  } estado_t;

  estado_t     estado;
  estado_t     estado_next;
  logic [31:0] prescaler;
  logic        tick;

  // Next state: clear and stop both force PARADO, stop beating a
  // simultaneous start. load does not touch the state.
  always_comb begin
    estado_next = estado;
    if (clear) begin
      estado_next = PARADO;
    end else if (stop) begin
      estado_next = PARADO;
    end else if (start) begin
      estado_next = CONTANDO;
    end
  end

  // The tick is decided by the state before the edge, so a stop sampled
  // on the tick edge still lets that second be counted.
  assign tick = (estado == CONTANDO) && (prescaler == (CLK_DIV - 32'd1));

  // All state lives here. The prescaler simply holds while PARADO so a
  // pause keeps the fractional second already accumulated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= PARADO;
      prescaler   <= 32'd0;
      seg_total   <= 32'd0;
      seg_captura <= 32'd0;
      seg_valid   <= 1'b0;
      contando    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      estado   <= estado_next;
      contando <= (estado_next == CONTANDO);

      // Capture always sees the value from before this edge's update.
      if (captura) begin
        seg_captura <= seg_total;
      end

      if (clear) begin
        seg_total <= 32'd0;
        prescaler <= 32'd0;
        overflow  <= 1'b0;
        seg_valid <= 1'b1;
      end else if (load) begin
        seg_total <= load_val;
        prescaler <= 32'd0;
        overflow  <= 1'b0;
        seg_valid <= 1'b1;
      end else if (tick) begin
        prescaler <= 32'd0;
        seg_valid <= 1'b1;
        if (seg_total == MAX_SEG) begin
          seg_total <= 32'd0;
          overflow  <= 1'b1;
        end else begin
          seg_total <= seg_total + 32'd1;
        end
      end else begin
        seg_valid <= 1'b0;
        if (estado == CONTANDO) begin
          prescaler <= prescaler + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_contador_segundos.sv
// tb_contador_segundos
// Self-checking bench for contador_segundos. Two instances share the
// control inputs: dut4 (CLK_DIV=4, full 32-bit range) and dutw (CLK_DIV=4,
// MAX_SEG=5) for wrap-around behaviour. The reference model describes the
// count as "loaded base plus whole seconds of running time, modulo the
// range" rather than as a prescaler register.
module tb_contador_segundos;

  localparam longint DIV    = 4;
  localparam longint RANGE4 = 64'h1_0000_0000;
  localparam longint RANGEW = 6;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        clear;
  logic        load;
  logic [31:0] load_val;
  logic [31:0] load_val_w;
  logic        captura;

  logic [31:0] st4, sc4, stw, scw;
  logic        sv4, ct4, of4, svw, ctw, ofw;

  int checks;
  int errors;

  typedef struct {
    longint base;
    longint run;
    bit     running;
    bit     valid;
    bit     ovf;
    longint cap;
  } model_t;

  model_t m4;
  model_t mw;

  // The wrap instance only ever sees legal load values.
  assign load_val_w = load_val % 32'd6;

  contador_segundos #(.CLK_DIV(32'd4), .MAX_SEG(32'hFFFFFFFF)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .captura(captura),
    .seg_total(st4), .seg_valid(sv4), .seg_captura(sc4),
    .contando(ct4), .overflow(of4)
  );

  contador_segundos #(.CLK_DIV(32'd4), .MAX_SEG(32'd5)) dutw (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val_w), .captura(captura),
    .seg_total(stw), .seg_valid(svw), .seg_captura(scw),
    .contando(ctw), .overflow(ofw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Seconds shown = base plus completed seconds of running time, wrapped.
  function automatic logic [31:0] model_total(model_t m, longint rng);
    return 32'((m.base + m.run / DIV) % rng);
  endfunction

  // One clock edge of the reference behaviour.
  function automatic model_t model_step(model_t m, bit st, bit sp, bit cl,
                                        bit ld, longint lv, bit cap,
                                        longint rng);
    model_t n = m;
    n.valid = 1'b0;
    if (cap) n.cap = (m.base + m.run / DIV) % rng;
    if (cl) begin
      n.base = 0; n.run = 0; n.ovf = 1'b0; n.valid = 1'b1; n.running = 1'b0;
    end else begin
      if (ld) begin
        n.base = lv; n.run = 0; n.ovf = 1'b0; n.valid = 1'b1;
      end else if (m.running) begin
        n.run = m.run + 1;
        if (n.run % DIV == 0) begin
          n.valid = 1'b1;
          if ((n.base + n.run / DIV) % rng == 0) n.ovf = 1'b1;
        end
      end
      if (sp) n.running = 1'b0;
      else if (st) n.running = 1'b1;
    end
    return n;
  endfunction

  function automatic model_t model_reset();
    model_t z;
    z.base = 0; z.run = 0; z.running = 1'b0; z.valid = 1'b0;
    z.ovf = 1'b0; z.cap = 0;
    return z;
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, and return 1 time unit later so outputs can be sampled.
  task automatic applyStimulus(input bit st, input bit sp, input bit cl,
                               input bit ld, input logic [31:0] lv,
                               input bit cap);
    @(negedge clk);
    start = st; stop = sp; clear = cl; load = ld; load_val = lv; captura = cap;
    @(posedge clk);
    m4 = model_step(m4, st, sp, cl, ld, longint'(lv), cap, RANGE4);
    mw = model_step(mw, st, sp, cl, ld, longint'(lv % 32'd6), cap, RANGEW);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 32'd0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({st4, sc4, sv4, ct4, of4} !== 67'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs total=%0d cap=%0d v=%b c=%b o=%b expected all 0",
               st4, sc4, sv4, ct4, of4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m4 = model_reset();
    mw = model_reset();
    idle(2);
    checks++;
    if (st4 !== 32'd0 || ct4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle total=%0d contando=%b expected 0/0", st4, ct4);
    end
  endtask

  task automatic test_first_ticks();
    applyStimulus(1, 0, 0, 0, 32'd0, 0);
    checks++;
    if (ct4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_contando got=%b expected=1", ct4);
    end
    for (int e = 1; e <= 12; e++) begin
      idle(1);
      checks++;
      if (st4 !== 32'(e / 4) || sv4 !== (e % 4 == 0)) begin
        errors++;
        $display("[TB] FAIL first_ticks edge=%0d total=%0d valid=%b expected=%0d/%b",
                 e, st4, sv4, e / 4, (e % 4 == 0));
      end
    end
  endtask

  task automatic test_pause();
    applyStimulus(0, 0, 1, 0, 32'd0, 0);
    applyStimulus(1, 0, 0, 0, 32'd0, 0);
    idle(5);
    applyStimulus(0, 1, 0, 0, 32'd0, 0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      checks++;
      if (st4 !== 32'd1 || ct4 !== 1'b0 || sv4 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pause_hold i=%0d total=%0d c=%b v=%b expected 1/0/0",
                 i, st4, ct4, sv4);
      end
    end
    applyStimulus(1, 0, 0, 0, 32'd0, 0);
    idle(1);
    checks++;
    if (st4 !== 32'd1) begin
      errors++;
      $display("[TB] FAIL resume_early total=%0d expected=1", st4);
    end
    idle(1);
    checks++;
    if (st4 !== 32'd2 || sv4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resume_tick total=%0d valid=%b expected=2/1", st4, sv4);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(0, 0, 1, 0, 32'd0, 0);
    applyStimulus(1, 0, 0, 1, 32'd5, 0);
    checks++;
    if (stw !== 32'd5 || ofw !== 1'b0 || svw !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_load total=%0d ovf=%b valid=%b expected 5/0/1", stw, ofw, svw);
    end
    idle(4);
    checks++;
    if (stw !== 32'd0 || ofw !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_tick total=%0d ovf=%b expected 0/1", stw, ofw);
    end
    idle(4);
    checks++;
    if (stw !== 32'd1 || ofw !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_sticky total=%0d ovf=%b expected 1/1", stw, ofw);
    end
    applyStimulus(0, 0, 1, 0, 32'd0, 0);
    checks++;
    if (stw !== 32'd0 || ofw !== 1'b0 || ctw !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_clear total=%0d ovf=%b c=%b expected 0/0/0", stw, ofw, ctw);
    end
  endtask

  task automatic test_load_clear();
    applyStimulus(1, 0, 0, 0, 32'd0, 0);
    idle(6);
    applyStimulus(0, 0, 1, 1, 32'd86399, 0);
    checks++;
    if (st4 !== 32'd0 || ct4 !== 1'b0 || sv4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_beats_load total=%0d c=%b v=%b expected 0/0/1", st4, ct4, sv4);
    end
    applyStimulus(1, 0, 0, 0, 32'd0, 0);
    idle(2);
    applyStimulus(0, 0, 0, 1, 32'd86399, 0);
    checks++;
    if (st4 !== 32'd86399 || ct4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_running total=%0d c=%b expected 86399/1", st4, ct4);
    end
    idle(3);
    checks++;
    if (st4 !== 32'd86399) begin
      errors++;
      $display("[TB] FAIL load_prescaler_zero total=%0d expected=86399", st4);
    end
    idle(1);
    checks++;
    if (st4 !== 32'd86400 || sv4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_then_tick total=%0d valid=%b expected 86400/1", st4, sv4);
    end
  endtask

  task automatic test_capture();
    applyStimulus(0, 0, 1, 0, 32'd0, 0);
    applyStimulus(1, 0, 0, 1, 32'd6, 0);
    idle(4);
    checks++;
    if (st4 !== 32'd7) begin
      errors++;
      $display("[TB] FAIL capture_setup total=%0d expected=7", st4);
    end
    idle(3);
    applyStimulus(0, 1, 0, 0, 32'd0, 1);
    checks++;
    if (sc4 !== 32'd7 || st4 !== 32'd8 || ct4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL capture_on_tick cap=%0d total=%0d c=%b expected 7/8/0",
               sc4, st4, ct4);
    end
    applyStimulus(1, 1, 0, 0, 32'd0, 0);
    idle(5);
    checks++;
    if (ct4 !== 1'b0 || st4 !== 32'd8) begin
      errors++;
      $display("[TB] FAIL start_stop_together c=%b total=%0d expected 0/8", ct4, st4);
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1, 0, 0, 0, 32'd0, 0);
    idle(6);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({st4, sc4, sv4, ct4, of4} !== 67'd0 || {stw, scw, svw, ctw, ofw} !== 67'd0) begin
      errors++;
      $display("[TB] FAIL async_reset total=%0d c=%b expected 0/0", st4, ct4);
    end
    m4 = model_reset();
    mw = model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    checks++;
    if (st4 !== 32'd0 || ct4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_resume_without_start total=%0d c=%b expected 0/0", st4, ct4);
    end
    applyStimulus(1, 0, 0, 0, 32'd0, 0);
    idle(4);
    checks++;
    if (st4 !== 32'd1) begin
      errors++;
      $display("[TB] FAIL resume_after_start total=%0d expected=1", st4);
    end
  endtask

  task automatic test_random();
    logic [31:0] lv;
    for (int i = 0; i < 600; i++) begin
      lv = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFE : $urandom;
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                    lv, $urandom_range(0, 7) == 0);
      checks++;
      if (st4 !== model_total(m4, RANGE4) || sv4 !== m4.valid ||
          sc4 !== 32'(m4.cap) || ct4 !== m4.running || of4 !== m4.ovf) begin
        errors++;
        $display("[TB] FAIL random4 i=%0d total=%0d/%0d v=%b/%b cap=%0d/%0d c=%b/%b o=%b/%b",
                 i, st4, model_total(m4, RANGE4), sv4, m4.valid, sc4, m4.cap,
                 ct4, m4.running, of4, m4.ovf);
      end
      checks++;
      if (stw !== model_total(mw, RANGEW) || svw !== mw.valid ||
          scw !== 32'(mw.cap) || ctw !== mw.running || ofw !== mw.ovf) begin
        errors++;
        $display("[TB] FAIL randomw i=%0d total=%0d/%0d v=%b/%b cap=%0d/%0d c=%b/%b o=%b/%b",
                 i, stw, model_total(mw, RANGEW), svw, mw.valid, scw, mw.cap,
                 ctw, mw.running, ofw, mw.ovf);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    start    = 1'b0;
    stop     = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = 32'd0;
    captura  = 1'b0;
    m4 = model_reset();
    mw = model_reset();
    test_reset();
    test_first_ticks();
    test_pause();
    test_wrap();
    test_load_clear();
    test_capture();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
